// File: rtl/arm_defs_pkg.sv
// rtl/arm_defs_pkg.sv - shared ARM core widths and EXE_CMD encodings
package arm_defs;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CMD_W  = 4;

  // ALU command encodings seen by the execute stage
  typedef enum logic [CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // Aliases: compare/test reuse SUB/AND, address generation reuses ADD
  localparam exe_cmd_e EXE_CMP = EXE_SUB;
  localparam exe_cmd_e EXE_TST = EXE_AND;
  localparam exe_cmd_e EXE_LDR = EXE_ADD;
  localparam exe_cmd_e EXE_STR = EXE_ADD;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with flush-to-zero and freeze-hold
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         freeze_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next state: flush beats freeze beats load; d_i is ignored unless loading
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (!freeze_i) begin
      q_d = d_i;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with flush and freeze
module id_exe_reg #(
  parameter int DATA_W = arm_defs::DATA_W,
  parameter int REG_AW = arm_defs::REG_AW,
  parameter int CMD_W  = arm_defs::CMD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic              carry_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic              carry_out
);

  localparam int CTRL_W = 7 + CMD_W;
  localparam int DATA_G = 3 * DATA_W;
  localparam int IMM_W  = 1 + 12 + 24;
  localparam int IDX_W  = 3 * REG_AW;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_G-1:0] data_q;
  logic [IMM_W-1:0]  imm_q;
  logic [IDX_W-1:0]  idx_q;

  // Control group; the constant 1 becomes valid_out so a load marks a real instruction
  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (flush),
    .freeze_i (freeze),
    .d_i      ({1'b1, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in, carry_in}),
    .q_o      (ctrl_q)
  );

  // Operand group; the register file writes on negedge so these are already current
  pipe_reg #(.W(DATA_G)) u_data (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (flush),
    .freeze_i (freeze),
    .d_i      ({pc_in, val_rn_in, val_rm_in}),
    .q_o      (data_q)
  );

  pipe_reg #(.W(IMM_W)) u_imm (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (flush),
    .freeze_i (freeze),
    .d_i      ({imm_in, shift_operand_in, signed_imm_24_in}),
    .q_o      (imm_q)
  );

  pipe_reg #(.W(IDX_W)) u_idx (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (flush),
    .freeze_i (freeze),
    .d_i      ({dest_in, src1_in, src2_in}),
    .q_o      (idx_q)
  );

  assign {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
          exe_cmd_out, carry_out}                      = ctrl_q;
  assign {pc_out, val_rn_out, val_rm_out}              = data_q;
  assign {imm_out, shift_operand_out, signed_imm_24_out} = imm_q;
  assign {dest_out, src1_out, src2_out}                = idx_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - directed table-driven bench for id_exe_reg
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        carry;
  } fields_t;

  typedef struct packed {
    logic    flush;
    logic    freeze;
    fields_t din;
    fields_t exp;
    logic    exp_valid;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;
  logic freeze;
  fields_t din;
  fields_t dout;
  logic    valid_out;

  logic        use_rf;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] rf [16];
  logic [31:0] val_rn_mux;

  logic [31:0] pc_o, rn_o, rm_o;
  logic        wb_o, mr_o, mw_o, b_o, s_o, imm_o, carry_o;
  logic [3:0]  cmd_o, dest_o, src1_o, src2_o;
  logic [11:0] sh_o;
  logic [23:0] si_o;

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: write on falling edge, combinational read
  always @(negedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
  end
  assign val_rn_mux = use_rf ? rf[din.src1] : din.rn;

  id_exe_reg dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .freeze            (freeze),
    .pc_in             (din.pc),
    .val_rn_in         (val_rn_mux),
    .val_rm_in         (din.rm),
    .wb_en_in          (din.wb),
    .mem_r_en_in       (din.mr),
    .mem_w_en_in       (din.mw),
    .b_in              (din.b),
    .s_in              (din.s),
    .exe_cmd_in        (din.cmd),
    .imm_in            (din.imm),
    .shift_operand_in  (din.sh),
    .signed_imm_24_in  (din.si),
    .dest_in           (din.dest),
    .src1_in           (din.src1),
    .src2_in           (din.src2),
    .carry_in          (din.carry),
    .valid_out         (valid_out),
    .pc_out            (pc_o),
    .val_rn_out        (rn_o),
    .val_rm_out        (rm_o),
    .wb_en_out         (wb_o),
    .mem_r_en_out      (mr_o),
    .mem_w_en_out      (mw_o),
    .b_out             (b_o),
    .s_out             (s_o),
    .exe_cmd_out       (cmd_o),
    .imm_out           (imm_o),
    .shift_operand_out (sh_o),
    .signed_imm_24_out (si_o),
    .dest_out          (dest_o),
    .src1_out          (src1_o),
    .src2_out          (src2_o),
    .carry_out         (carry_o)
  );

  assign dout = {pc_o, rn_o, rm_o, wb_o, mr_o, mw_o, b_o, s_o, cmd_o, imm_o,
                 sh_o, si_o, dest_o, src1_o, src2_o, carry_o};

  function automatic fields_t mk(logic [31:0] pc, logic [31:0] rn, logic [31:0] rm,
                                 logic [4:0] ctl, logic [3:0] cmd, logic imm,
                                 logic [11:0] sh, logic [23:0] si, logic [3:0] d,
                                 logic [3:0] s1, logic [3:0] s2, logic c);
    fields_t f;
    f.pc = pc; f.rn = rn; f.rm = rm;
    {f.wb, f.mr, f.mw, f.b, f.s} = ctl;
    f.cmd = cmd; f.imm = imm; f.sh = sh; f.si = si;
    f.dest = d; f.src1 = s1; f.src2 = s2; f.carry = c;
    return f;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t    tbl [10];
  fields_t va, vb, vc, vz, vx;

  initial begin
    va = mk(32'h0000_0008, 32'h1234_5678, 32'hFFFF_FFFF, 5'b10000, 4'b0010, 1'b1,
            12'hABC, 24'h123456, 4'd7, 4'd1, 4'd2, 1'b1);
    vb = mk(32'hFFFF_FFFC, 32'h0000_0000, 32'hDEAD_BEEF, 5'b01001, 4'b1001, 1'b0,
            12'hFFF, 24'hFFFFFF, 4'd15, 4'd15, 4'd0, 1'b0);
    vc = mk(32'h0000_0040, 32'hA5A5_A5A5, 32'h0000_0001, 5'b10110, 4'b0101, 1'b1,
            12'h001, 24'h800000, 4'd14, 4'd3, 4'd9, 1'b1);
    vz = '0;
    vx = 'x;

    //             flush freeze din exp valid
    tbl[0] = '{1'b0, 1'b0, va, va, 1'b1};
    tbl[1] = '{1'b0, 1'b0, vb, vb, 1'b1};
    tbl[2] = '{1'b0, 1'b1, vc, vb, 1'b1};
    tbl[3] = '{1'b1, 1'b0, vc, vz, 1'b0};
    tbl[4] = '{1'b0, 1'b1, vc, vz, 1'b0};
    tbl[5] = '{1'b0, 1'b0, vc, vc, 1'b1};
    tbl[6] = '{1'b1, 1'b1, va, vz, 1'b0};
    tbl[7] = '{1'b0, 1'b1, vx, vz, 1'b0};
    tbl[8] = '{1'b1, 1'b0, vx, vz, 1'b0};
    tbl[9] = '{1'b0, 1'b0, va, va, 1'b1};

    for (int i = 0; i < 16; i++) rf[i] = '0;
    use_rf = 1'b0;
    rf_we  = 1'b0;
    rf_wa  = '0;
    rf_wd  = '0;

    // Reset asserted before any clock edge with nonzero inputs
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; din = va;
    #2;
    chk("reset_fields", 160'(dout), 160'(vz));
    chk("reset_valid", 160'(valid_out), 160'(1'b0));
    #1;
    rst = 1'b1;
    din.pc = 32'h0000_0004;
    step();
    chk("first_load_pc", 160'(pc_o), 160'(32'h4));
    chk("first_load_valid", 160'(valid_out), 160'(1'b1));

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      flush = tbl[i].flush; freeze = tbl[i].freeze; din = tbl[i].din;
      step();
      chk($sformatf("vec%0d_fields", i), 160'(dout), 160'(tbl[i].exp));
      chk($sformatf("vec%0d_valid", i), 160'(valid_out), 160'(tbl[i].exp_valid));
    end

    // Freeze held for three cycles, then released
    flush = 1'b0; freeze = 1'b0; din = vb; din.pc = 32'h10;
    step();
    chk("frz_load_pc", 160'(pc_o), 160'(32'h10));
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din.pc = 32'h14 + 32'(4 * i);
      step();
      chk($sformatf("frz%0d_pc", i), 160'(pc_o), 160'(32'h10));
      chk($sformatf("frz%0d_valid", i), 160'(valid_out), 160'(1'b1));
    end
    freeze = 1'b0;
    step();
    chk("frz_release_pc", 160'(pc_o), 160'(32'h1C));

    // Register written on negedge is captured by the next rising edge
    din = va; din.rn = 32'h55; din.src1 = 4'd3;
    use_rf = 1'b1; rf_we = 1'b1; rf_wa = 4'd3; rf_wd = 32'hAB;
    step();
    chk("wb_fwd_rn", 160'(rn_o), 160'(32'hAB));
    use_rf = 1'b0; rf_we = 1'b0;

    // Asynchronous reset in the middle of a cycle
    din = vc;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_fields", 160'(dout), 160'(vz));
    chk("async_rst_valid", 160'(valid_out), 160'(1'b0));
    rst = 1'b1; freeze = 1'b1;
    step();
    chk("frz_after_rst_valid", 160'(valid_out), 160'(1'b0));
    chk("frz_after_rst_fields", 160'(dout), 160'(vz));
    freeze = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
